// File: rtl/mac_ctrl_pkg.sv
// Shared types and helpers for the MAC array sequencer.
//   state_e      : sequencer FSM states
//   AW_DEF       : default SRAM address width
//   RES_LAT_DEF  : default array input-to-result latency
//   IDX_W        : width of the vector index carried down the pipelines
//   col_mask()   : active column count -> thermometer weight-enable mask
package mac_ctrl_pkg;

  localparam int AW_DEF      = 8;
  localparam int RES_LAT_DEF = 6;
  localparam int IDX_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Column 1 is the MSB of the mask; 0 or >4 columns means all four.
  function automatic logic [3:0] col_mask(input logic [2:0] cols);
    case (cols)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b1100;
      3'd3:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// Fixed-depth shift register carrying {valid, index}.
//   CLK, RSTN         : clock, async active-low reset
//   in_vld, in_idx    : stage-0 input
//   out_vld, out_idx  : same values DEPTH cycles later
module ctrl_delay_line #(
  parameter int DEPTH = 1,
  parameter int IW    = 8
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          in_vld,
  input  logic [IW-1:0] in_idx,
  output logic          out_vld,
  output logic [IW-1:0] out_idx
);

  logic [DEPTH:1]         vld_pipe_d, vld_pipe_q;
  logic [DEPTH:1][IW-1:0] idx_pipe_d, idx_pipe_q;

  always_comb begin
    vld_pipe_d[1] = in_vld;
    idx_pipe_d[1] = in_idx;
    for (int s = 2; s <= DEPTH; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      idx_pipe_d[s] = idx_pipe_q[s-1];
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      idx_pipe_q <= idx_pipe_d;
    end
  end

  assign out_vld = vld_pipe_q[DEPTH];
  assign out_idx = idx_pipe_q[DEPTH];

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for the 4x4 weight-stationary MAC array.
// Loads one weight tile, streams N input vectors (optionally reading back
// partial sums) and writes the N aligned results to output SRAM.
//   start / cfg_*        : job request and descriptor (latched on accept)
//   busy / done          : job status, one-cycle done pulse
//   w_rd_*, x_rd_*, p_rd_*: weight / input / partial-sum SRAM reads
//   o_wr_*               : result write port (data = result_i pass-through)
//   result_i             : aligned array result word
//   en_x_i, en_w_i, stop_mac, used_row, overwrite_sig : array controls
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int RES_LAT = RES_LAT_DEF
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          start,
  input  logic [2:0]    cfg_cols,
  input  logic [7:0]    cfg_len,
  input  logic          cfg_acc,
  input  logic [AW-1:0] cfg_w_base,
  input  logic [AW-1:0] cfg_x_base,
  input  logic [AW-1:0] cfg_o_base,
  output logic          busy,
  output logic          done,
  output logic          w_rd_en,
  output logic [AW-1:0] w_rd_addr,
  output logic          x_rd_en,
  output logic [AW-1:0] x_rd_addr,
  output logic          p_rd_en,
  output logic [AW-1:0] p_rd_addr,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [63:0]   o_wr_data,
  input  logic [63:0]   result_i,
  output logic          en_x_i,
  output logic [3:0]    en_w_i,
  output logic          stop_mac,
  output logic          used_row,
  output logic          overwrite_sig
);

  state_e           state_d, state_q;
  logic [IDX_W-1:0] cnt_d, cnt_q;
  logic [2:0]       cols_d, cols_q;
  logic [7:0]       len_d, len_q;
  logic             acc_d, acc_q;
  logic [AW-1:0]    w_base_d, w_base_q;
  logic [AW-1:0]    x_base_d, x_base_q;
  logic [AW-1:0]    o_base_d, o_base_q;

  logic             ew_vld;
  logic [3:0]       ew_mask;
  logic             ex_vld;
  logic [IDX_W-1:0] ex_idx;
  logic             wr_vld;
  logic [IDX_W-1:0] wr_idx;
  logic             last_wr;

  // The write stream ends with index N-1; nothing else bounds DRAIN.
  assign last_wr = wr_vld && (wr_idx == len_q - 8'd1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cols_d   = cols_q;
    len_d    = len_q;
    acc_d    = acc_q;
    w_base_d = w_base_q;
    x_base_d = x_base_q;
    o_base_d = o_base_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cols_d   = cfg_cols;
          len_d    = cfg_len;
          acc_d    = cfg_acc;
          w_base_d = cfg_w_base;
          x_base_d = cfg_x_base;
          o_base_d = cfg_o_base;
          cnt_d    = '0;
          state_d  = ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        if (cnt_q == 8'd3) begin
          cnt_d   = '0;
          state_d = (len_q == 8'd0) ? ST_DRAIN : ST_STREAM;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_STREAM: begin
        if (cnt_q == len_q - 8'd1) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DRAIN: begin
        if (len_q == 8'd0 || last_wr) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cols_q   <= '0;
      len_q    <= '0;
      acc_q    <= 1'b0;
      w_base_q <= '0;
      x_base_q <= '0;
      o_base_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cols_q   <= cols_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      w_base_q <= w_base_d;
      x_base_q <= x_base_d;
      o_base_q <= o_base_d;
    end
  end

  assign busy     = (state_q == ST_LOAD_W) || (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
  assign used_row = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign stop_mac = (state_q == ST_DRAIN);
  assign overwrite_sig = busy && acc_q;

  // Addresses are forced to zero whenever their strobe is low.
  assign w_rd_en   = (state_q == ST_LOAD_W);
  assign w_rd_addr = w_rd_en ? w_base_q + AW'(cnt_q) : '0;
  assign x_rd_en   = (state_q == ST_STREAM);
  assign x_rd_addr = x_rd_en ? x_base_q + AW'(cnt_q) : '0;
  assign p_rd_en   = x_rd_en && acc_q;
  assign p_rd_addr = p_rd_en ? o_base_q + AW'(cnt_q) : '0;

  // Weight data returns one cycle after the read; the mask rides along as
  // the index so the enable lines up with the returning row.
  ctrl_delay_line #(.DEPTH(1), .IW(4)) u_ew_align (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .in_vld  (w_rd_en),
    .in_idx  (w_rd_en ? col_mask(cols_q) : 4'b0000),
    .out_vld (ew_vld),
    .out_idx (ew_mask)
  );
  assign en_w_i = ew_vld ? ew_mask : 4'b0000;

  // Input data returns one cycle after the read.
  ctrl_delay_line #(.DEPTH(1), .IW(IDX_W)) u_ex_align (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .in_vld  (x_rd_en),
    .in_idx  (cnt_q),
    .out_vld (ex_vld),
    .out_idx (ex_idx)
  );
  assign en_x_i = ex_vld;

  // Result for vector k appears RES_LAT cycles after its array sample.
  ctrl_delay_line #(.DEPTH(RES_LAT), .IW(IDX_W)) u_wr_align (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .in_vld  (ex_vld),
    .in_idx  (ex_idx),
    .out_vld (wr_vld),
    .out_idx (wr_idx)
  );
  assign o_wr_en   = wr_vld;
  assign o_wr_addr = wr_vld ? o_base_q + AW'(wr_idx) : '0;
  assign o_wr_data = wr_vld ? result_i : 64'd0;

endmodule
